// File: rtl/elastic_fu_param.sv
// Elastic functional unit for one CGRA PE: valid/stop handshake on both sides,
// per-opcode multi-cycle latency and a data-memory port for LOAD/STORE.
module elastic_fu_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int OP_WIDTH   = 4,
    parameter int LAT_ADD    = 1,
    parameter int LAT_MUL    = 2,
    parameter int LAT_DIV    = 8,
    parameter int LAT_MEM    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] const_data,
    input  logic                  valid_input,
    output logic                  stop_input,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  valid_output,
    input  logic                  stop_output,
    output logic                  div_zero,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  switch_context
);

    localparam int MAX_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int MAX_DM  = (LAT_DIV > LAT_MEM) ? LAT_DIV : LAT_MEM;
    localparam int MAX_LAT = (MAX_AM > MAX_DM) ? MAX_AM : MAX_DM;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_CONST = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_STORE = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_ROUTE = OP_WIDTH'(8);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      counter;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, c_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  in_xfer, out_xfer;
    logic [CNT_W-1:0]      accept_lat;
    logic [DATA_WIDTH:0]   accept_res, exec_res;

    function automatic logic [CNT_W-1:0] lat_of(input logic [OP_WIDTH-1:0] o);
        case (o)
            OP_MUL:           lat_of = CNT_W'(LAT_MUL);
            OP_DIV:           lat_of = CNT_W'(LAT_DIV);
            OP_LOAD, OP_STORE: lat_of = CNT_W'(LAT_MEM);
            default:          lat_of = CNT_W'(LAT_ADD);
        endcase
    endfunction

    // Returns {div_zero, result}; unknown opcodes fall through to the NOP result.
    function automatic logic [DATA_WIDTH:0] compute(
        input logic [OP_WIDTH-1:0]   o,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [DATA_WIDTH-1:0] c,
        input logic [DATA_WIDTH-1:0] rd
    );
        compute = '0;
        case (o)
            OP_ADD:   compute[DATA_WIDTH-1:0] = a + b;
            OP_SUB:   compute[DATA_WIDTH-1:0] = a - b;
            OP_MUL:   compute[DATA_WIDTH-1:0] = a * b;
            OP_DIV: begin
                if (b == '0) compute = {1'b1, {DATA_WIDTH{1'b1}}};
                else         compute[DATA_WIDTH-1:0] = a / b;
            end
            OP_CONST: compute[DATA_WIDTH-1:0] = c;
            OP_LOAD:  compute[DATA_WIDTH-1:0] = rd;
            OP_STORE: compute[DATA_WIDTH-1:0] = b;
            OP_ROUTE: compute[DATA_WIDTH-1:0] = a;
            default:  compute = '0;
        endcase
    endfunction

    assign valid_output   = (state == DONE);
    assign stop_input     = (state == EXEC) || ((state == DONE) && stop_output);
    assign in_xfer        = valid_input && !stop_input;
    assign out_xfer       = valid_output && !stop_output;
    assign switch_context = out_xfer;

    assign accept_lat = lat_of(op);
    assign accept_res = compute(op, in1, in2, const_data, mem_rd_data);
    assign exec_res   = compute(op_q, a_q, b_q, c_q, mem_rd_data);

    // The read address is presented in the accept cycle so a 1-clk memory has data by the final EXEC edge.
    assign mem_rd_addr = (in_xfer && op == OP_LOAD) ? in1[ADDR_WIDTH-1:0] : rd_addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            counter     <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            out_data    <= '0;
            div_zero    <= 1'b0;
            rd_addr_q   <= '0;
            mem_wr      <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_wr <= 1'b0;
            case (state)
                EXEC: begin
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        {div_zero, out_data} <= exec_res;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_xfer) state <= IDLE;
                end
                default: ;
            endcase

            // Accept overrides the DONE->IDLE step so a handoff cycle can take a new token.
            if (in_xfer) begin
                op_q    <= op;
                a_q     <= in1;
                b_q     <= in2;
                c_q     <= const_data;
                counter <= accept_lat - CNT_W'(1);
                if (accept_lat == CNT_W'(1)) begin
                    {div_zero, out_data} <= accept_res;
                    state <= DONE;
                end else begin
                    state <= EXEC;
                end
                if (op == OP_LOAD) rd_addr_q <= in1[ADDR_WIDTH-1:0];
                if (op == OP_STORE) begin
                    mem_wr      <= 1'b1;
                    mem_wr_addr <= in1[ADDR_WIDTH-1:0];
                    mem_wr_data <= in2;
                end
            end
        end
    end

endmodule

// File: tb/tb_elastic_fu_param.sv
// Bench for elastic_fu_param: directed vector table, hand-written handshake
// corner cases, then random traffic checked against a token-level model.
module tb_elastic_fu_param;

    localparam int L_ADD = 1;
    localparam int L_MUL = 2;
    localparam int L_DIV = 8;
    localparam int L_MEM = 2;

    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, MUL = 4'd3, DIV = 4'd4;
    localparam logic [3:0] CONST = 4'd5, LOAD = 4'd6, STORE = 4'd7, ROUTE = 4'd8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in1, in2, const_data, out_data, mem_rd_data, mem_wr_data;
    logic [3:0]  op;
    logic        valid_input, stop_input, valid_output, stop_output, div_zero;
    logic        mem_wr, switch_context;
    logic [15:0] mem_rd_addr, mem_wr_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    logic [31:0] model_mem [0:255];
    bit          mem_ready = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, c;
        logic [31:0] exp_data;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs [14];

    elastic_fu_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .OP_WIDTH(4),
        .LAT_ADD(L_ADD), .LAT_MUL(L_MUL), .LAT_DIV(L_DIV), .LAT_MEM(L_MEM)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in1(in1), .in2(in2), .op(op),
        .const_data(const_data), .valid_input(valid_input), .stop_input(stop_input),
        .out_data(out_data), .valid_output(valid_output), .stop_output(stop_output),
        .div_zero(div_zero), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .switch_context(switch_context)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int i);
        return 32'hA500_0000 ^ 32'(i * 257);
    endfunction

    // Synchronous-read data memory: data appears one clock after the address.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
            mem_ready <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_wr_addr[7:0]] <= mem_wr_data;
        end
        mem_rd_data <= mem[mem_rd_addr[7:0]];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // One isolated token: accept, scramble inputs, wait for the result, hand it off.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, output logic [31:0] data,
                                 output logic dz, output int lat);
        op = o; in1 = a; in2 = b; const_data = c;
        valid_input = 1'b1; stop_output = 1'b0;
        tick();
        valid_input = 1'b0;
        op = 4'($urandom); in1 = $urandom; in2 = $urandom; const_data = $urandom;
        lat = 1;
        while (!valid_output && lat < 40) begin
            tick();
            lat++;
        end
        data = out_data;
        dz = div_zero;
        tick();
    endtask

    function automatic int ref_lat(input logic [3:0] o);
        if (o == MUL) return L_MUL;
        if (o == DIV) return L_DIV;
        if (o == LOAD || o == STORE) return L_MEM;
        return L_ADD;
    endfunction

    function automatic logic [32:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] c);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        case (o)
            ADD:   return {1'b0, a + b};
            SUB:   return {1'b0, a - b};
            MUL:   return {1'b0, prod[31:0]};
            DIV:   return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
            CONST: return {1'b0, c};
            LOAD:  return {1'b0, model_mem[a[7:0]]};
            STORE: return {1'b0, b};
            ROUTE: return {1'b0, a};
            default: return 33'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] data;
        logic        dz;
        int          lat;
        int          cyc, ready_cyc, wr_cyc;
        bit          have_tok, exp_valid, exp_stop;
        logic [32:0] tok_res;
        logic [15:0] wr_addr;
        logic [31:0] wr_data;

        for (int i = 0; i < 256; i++) model_mem[i] = pattern(i);

        vecs[0]  = '{ADD,   32'd3,          32'd4,       32'd0,          32'd7,          1'b0, L_ADD};
        vecs[1]  = '{SUB,   32'd3,          32'd5,       32'd0,          32'hFFFF_FFFE,  1'b0, L_ADD};
        vecs[2]  = '{MUL,   32'hFFFF_FFFF,  32'd2,       32'd0,          32'hFFFF_FFFE,  1'b0, L_MUL};
        vecs[3]  = '{MUL,   32'h0001_0000,  32'h0001_0000, 32'd0,        32'd0,          1'b0, L_MUL};
        vecs[4]  = '{DIV,   32'd10,         32'd0,       32'd0,          32'hFFFF_FFFF,  1'b1, L_DIV};
        vecs[5]  = '{DIV,   32'd10,         32'd3,       32'd0,          32'd3,          1'b0, L_DIV};
        vecs[6]  = '{CONST, 32'd1,          32'd2,       32'hDEAD_BEEF,  32'hDEAD_BEEF,  1'b0, L_ADD};
        vecs[7]  = '{ROUTE, 32'h1234_5678,  32'd9,       32'd7,          32'h1234_5678,  1'b0, L_ADD};
        vecs[8]  = '{NOP,   32'd5,          32'd6,       32'd7,          32'd0,          1'b0, L_ADD};
        vecs[9]  = '{4'd9,  32'd5,          32'd6,       32'd7,          32'd0,          1'b0, L_ADD};
        vecs[10] = '{4'd15, 32'd5,          32'd6,       32'd7,          32'd0,          1'b0, L_ADD};
        vecs[11] = '{STORE, 32'h20,         32'h1234,    32'd0,          32'h1234,       1'b0, L_MEM};
        vecs[12] = '{LOAD,  32'h20,         32'd0,       32'd0,          32'h1234,       1'b0, L_MEM};
        vecs[13] = '{ADD,   32'hFFFF_FFFF,  32'd1,       32'd0,          32'd0,          1'b0, L_ADD};

        reset_n = 1'b0; valid_input = 1'b0; stop_output = 1'b0;
        op = '0; in1 = '0; in2 = '0; const_data = '0;
        repeat (3) tick();
        checkOutput("reset_valid_output", valid_output, 1'b0);
        checkOutput("reset_stop_input", stop_input, 1'b0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_div_zero", div_zero, 1'b0);
        checkOutput("reset_mem_wr", mem_wr, 1'b0);
        checkOutput("reset_mem_wr_addr", mem_wr_addr, 16'd0);
        checkOutput("reset_mem_rd_addr", mem_rd_addr, 16'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, data, dz, lat);
            checkOutput($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_div_zero", i), dz, vecs[i].exp_dz);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // Back-to-back ADD stream with valid_input held high
        op = ADD; in1 = 32'd3; in2 = 32'd4; valid_input = 1'b1; stop_output = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("stream%0d_valid", k), valid_output, 1'b1);
            checkOutput($sformatf("stream%0d_data", k), out_data, 32'(7 + k));
            if (k < 3) in2 = 32'(5 + k);
            else       valid_input = 1'b0;
            #1;
            checkOutput($sformatf("stream%0d_switch", k), switch_context, 1'b1);
        end
        tick();
        checkOutput("stream_end_valid", valid_output, 1'b0);

        // MUL: back-pressure during EXEC, result two clocks after accept
        op = MUL; in1 = 32'hFFFF_FFFF; in2 = 32'd2; valid_input = 1'b1;
        #1;
        checkOutput("mul_accept_stop", stop_input, 1'b0);
        tick();
        valid_input = 1'b0;
        checkOutput("mul_exec_stop", stop_input, 1'b1);
        checkOutput("mul_exec_valid", valid_output, 1'b0);
        tick();
        checkOutput("mul_done_valid", valid_output, 1'b1);
        checkOutput("mul_done_data", out_data, 32'hFFFF_FFFE);
        tick();

        // STORE pulse then LOAD back
        op = STORE; in1 = 32'h10; in2 = 32'h55; valid_input = 1'b1;
        tick();
        valid_input = 1'b0; in1 = 32'h77; in2 = 32'h99;
        checkOutput("store_wr_pulse", mem_wr, 1'b1);
        checkOutput("store_wr_addr", mem_wr_addr, 16'h10);
        checkOutput("store_wr_data", mem_wr_data, 32'h55);
        tick();
        checkOutput("store_wr_end", mem_wr, 1'b0);
        checkOutput("store_result", out_data, 32'h55);
        tick();
        applyStimulus(LOAD, 32'h10, 32'd0, 32'd0, data, dz, lat);
        checkOutput("load_data", data, 32'h55);

        // Output stall in DONE, then handoff and accept in the same clock
        op = ADD; in1 = 32'd1; in2 = 32'd1; valid_input = 1'b1; stop_output = 1'b1;
        tick();
        in1 = 32'd5; in2 = 32'd6;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("stall%0d_stop", k), stop_input, 1'b1);
            checkOutput($sformatf("stall%0d_valid", k), valid_output, 1'b1);
            checkOutput($sformatf("stall%0d_data", k), out_data, 32'd2);
            checkOutput($sformatf("stall%0d_switch", k), switch_context, 1'b0);
            tick();
        end
        stop_output = 1'b0;
        #1;
        checkOutput("release_switch", switch_context, 1'b1);
        checkOutput("release_stop", stop_input, 1'b0);
        tick();
        valid_input = 1'b0;
        checkOutput("release_new_valid", valid_output, 1'b1);
        checkOutput("release_new_data", out_data, 32'd11);
        tick();
        checkOutput("release_idle", valid_output, 1'b0);

        // Reset in the middle of a DIV
        op = DIV; in1 = 32'd100; in2 = 32'd7; valid_input = 1'b1;
        tick();
        valid_input = 1'b0;
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_valid", valid_output, 1'b0);
        checkOutput("midrst_stop", stop_input, 1'b0);
        checkOutput("midrst_data", out_data, 32'd0);
        checkOutput("midrst_wr_addr", mem_wr_addr, 16'd0);
        checkOutput("midrst_wr_data", mem_wr_data, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        checkOutput("postrst_valid", valid_output, 1'b0);
        applyStimulus(ADD, 32'd20, 32'd22, 32'd0, data, dz, lat);
        checkOutput("postrst_add_data", data, 32'd42);
        checkOutput("postrst_add_latency", lat, L_ADD);

        // Random traffic against a token-level timing model
        cyc = 0; have_tok = 1'b0; ready_cyc = 0; wr_cyc = -1;
        tok_res = '0; wr_addr = '0; wr_data = '0;
        for (int n = 0; n < 400; n++) begin
            exp_valid = have_tok && (cyc >= ready_cyc);
            checkOutput("rnd_valid", valid_output, exp_valid);
            if (exp_valid) begin
                checkOutput("rnd_data", out_data, tok_res[31:0]);
                checkOutput("rnd_div_zero", div_zero, tok_res[32]);
            end
            checkOutput("rnd_mem_wr", mem_wr, cyc == wr_cyc);
            if (cyc == wr_cyc) begin
                checkOutput("rnd_wr_addr", mem_wr_addr, wr_addr);
                checkOutput("rnd_wr_data", mem_wr_data, wr_data);
            end

            valid_input = (n < 370) && ($urandom_range(0, 9) < 7);
            stop_output = ($urandom_range(0, 9) < 3);
            op = 4'($urandom_range(0, 10));
            in1 = (op == LOAD || op == STORE) ? 32'($urandom_range(128, 143)) : $urandom;
            in2 = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            const_data = $urandom;
            #1;
            exp_stop = have_tok && !(exp_valid && !stop_output);
            checkOutput("rnd_stop_input", stop_input, exp_stop);
            checkOutput("rnd_switch", switch_context, exp_valid && !stop_output);

            if (exp_valid && !stop_output) have_tok = 1'b0;
            if (valid_input && !exp_stop) begin
                have_tok  = 1'b1;
                ready_cyc = cyc + ref_lat(op);
                tok_res   = ref_result(op, in1, in2, const_data);
                if (op == STORE) begin
                    wr_cyc  = cyc + 1;
                    wr_addr = in1[15:0];
                    wr_data = in2;
                    model_mem[in1[7:0]] = in2;
                end
            end
            tick();
            cyc++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
